// File: rtl/branch_resolve.sv
// Branch resolution controller: detects mispredictions, issues a held redirect
// plus a one-cycle flush, and queues predictor-update records in a small FIFO.
module branch_resolve #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned UPD_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_npc,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] ex_pred_addr,
  output logic            ex_ready,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_addr,
  output logic            flush,
  output logic            upd_valid,
  input  logic            upd_ready,
  output logic [XLEN-1:0] upd_pc,
  output logic            upd_taken,
  output logic [XLEN-1:0] upd_target,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispred_count
);

  localparam int unsigned AW = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } upd_t;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t          state, state_d;
  upd_t            mem [UPD_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic [CW-1:0]   count, count_d;
  logic            redirect_valid_d, flush_d;
  logic [XLEN-1:0] redirect_addr_d;
  logic [31:0]     branch_count_d, mispred_count_d;

  logic            fifo_full, accept, actual_taken, mispredict, push, pop;
  logic [XLEN-1:0] actual_next;
  upd_t            push_entry;

  assign fifo_full    = (count == CW'(UPD_DEPTH));
  assign ex_ready     = (state == IDLE) && !fifo_full;
  assign accept       = ex_valid && ex_ready && (ex_branch || ex_jump);
  assign actual_taken = ex_jump || (ex_branch && ex_taken);
  assign actual_next  = actual_taken ? ex_target : ex_npc;
  assign mispredict   = (actual_next != ex_pred_addr);
  assign push         = accept;
  assign pop          = upd_valid && upd_ready;
  assign push_entry   = '{pc: ex_pc, taken: actual_taken, target: ex_target};

  assign upd_valid  = (count != '0);
  assign upd_pc     = mem[rd_ptr].pc;
  assign upd_taken  = mem[rd_ptr].taken;
  assign upd_target = mem[rd_ptr].target;

  // Next-state, redirect/flush, counters and FIFO bookkeeping
  always_comb begin
    state_d          = state;
    redirect_valid_d = redirect_valid;
    redirect_addr_d  = redirect_addr;
    flush_d          = 1'b0;
    branch_count_d   = branch_count;
    mispred_count_d  = mispred_count;
    wr_ptr_d         = wr_ptr;
    rd_ptr_d         = rd_ptr;
    count_d          = count + CW'(push) - CW'(pop);

    if (push) wr_ptr_d = wr_ptr + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr + AW'(1);

    case (state)
      IDLE: begin
        if (accept) begin
          branch_count_d = branch_count + 32'd1;
          if (mispredict) begin
            mispred_count_d  = mispred_count + 32'd1;
            redirect_addr_d  = actual_next;
            redirect_valid_d = 1'b1;
            flush_d          = 1'b1;
            state_d          = REDIRECT;
          end
        end
      end
      REDIRECT: begin
        if (redirect_valid && redirect_ready) begin
          redirect_valid_d = 1'b0;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registers are loaded every cycle so an externally preloaded counter is retained
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
      flush          <= 1'b0;
      branch_count   <= '0;
      mispred_count  <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      for (int i = 0; i < int'(UPD_DEPTH); i++) mem[i] <= '0;
    end else begin
      state          <= state_d;
      redirect_valid <= redirect_valid_d;
      redirect_addr  <= redirect_addr_d;
      flush          <= flush_d;
      branch_count   <= branch_count_d;
      mispred_count  <= mispred_count_d;
      wr_ptr         <= wr_ptr_d;
      rd_ptr         <= rd_ptr_d;
      count          <= count_d;
      if (push) mem[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with an update-record scoreboard.
module tb_branch_resolve;

  localparam int unsigned XLEN = 32;
  localparam int unsigned DEPTH = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            ex_valid, ex_branch, ex_jump, ex_taken;
  logic [XLEN-1:0] ex_pc, ex_npc, ex_target, ex_pred_addr;
  logic            ex_ready, redirect_valid, redirect_ready, flush;
  logic [XLEN-1:0] redirect_addr;
  logic            upd_valid, upd_ready, upd_taken;
  logic [XLEN-1:0] upd_pc, upd_target;
  logic [31:0]     branch_count, mispred_count;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  branch_resolve #(.XLEN(XLEN), .UPD_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_taken(ex_taken),
    .ex_pc(ex_pc), .ex_npc(ex_npc), .ex_target(ex_target), .ex_pred_addr(ex_pred_addr),
    .ex_ready(ex_ready),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_addr(redirect_addr), .flush(flush),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .branch_count(branch_count), .mispred_count(mispred_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Compare any head consumed at the coming edge, then advance one cycle
  task automatic tick();
    exp_t e;
    if (upd_valid === 1'b1 && upd_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("pop_pc", 64'(upd_pc), 64'(e.pc));
        chk("pop_taken", 64'(upd_taken), 64'(e.taken));
        chk("pop_target", 64'(upd_target), 64'(e.target));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input logic br, input logic jp, input logic tk, input logic [31:0] pc,
                     input logic [31:0] npc, input logic [31:0] tgt, input logic [31:0] pred);
    ex_valid = 1'b1; ex_branch = br; ex_jump = jp; ex_taken = tk;
    ex_pc = pc; ex_npc = npc; ex_target = tgt; ex_pred_addr = pred;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0; ex_taken = 1'b0;
  endtask

  initial begin
    logic [31:0] pc, tgt, npc;
    logic        tk;
    reset = 1'b1; redirect_ready = 1'b0; upd_ready = 1'b0;
    ex_pc = '0; ex_npc = '0; ex_target = '0; ex_pred_addr = '0;
    idle_in();
    tick(); tick();
    reset = 1'b0;
    chk("rst_rv", 64'(redirect_valid), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_raddr", 64'(redirect_addr), 64'd0);
    chk("rst_uvalid", 64'(upd_valid), 64'd0);
    chk("rst_upc", 64'(upd_pc), 64'd0);
    chk("rst_utaken", 64'(upd_taken), 64'd0);
    chk("rst_utgt", 64'(upd_target), 64'd0);
    chk("rst_bc", 64'(branch_count), 64'd0);
    chk("rst_mc", 64'(mispred_count), 64'd0);
    chk("rst_exr", 64'(ex_ready), 64'd1);

    // Correctly predicted taken branch
    drv(1, 0, 1, 32'h40, 32'h44, 32'h100, 32'h100);
    sb.push_back('{pc: 32'h40, taken: 1'b1, target: 32'h100});
    tick(); idle_in();
    chk("ok_flush", 64'(flush), 64'd0);
    chk("ok_rv", 64'(redirect_valid), 64'd0);
    chk("ok_bc", 64'(branch_count), 64'd1);
    chk("ok_mc", 64'(mispred_count), 64'd0);
    chk("ok_uvalid", 64'(upd_valid), 64'd1);
    chk("ok_upc", 64'(upd_pc), 64'h40);
    chk("ok_utaken", 64'(upd_taken), 64'd1);
    chk("ok_utgt", 64'(upd_target), 64'h100);
    upd_ready = 1'b1; tick(); upd_ready = 1'b0;
    chk("ok_drained", 64'(upd_valid), 64'd0);

    // Not-taken mispredict, redirect held for three cycles with wrong-path traffic
    drv(1, 0, 0, 32'h200, 32'h204, 32'h280, 32'h300);
    sb.push_back('{pc: 32'h200, taken: 1'b0, target: 32'h280});
    tick();
    chk("nt_flush", 64'(flush), 64'd1);
    chk("nt_rv", 64'(redirect_valid), 64'd1);
    chk("nt_raddr", 64'(redirect_addr), 64'h204);
    chk("nt_bc", 64'(branch_count), 64'd2);
    chk("nt_mc", 64'(mispred_count), 64'd1);
    chk("nt_exr", 64'(ex_ready), 64'd0);
    drv(1, 0, 1, 32'h500, 32'h504, 32'h600, 32'h700);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_flush", 64'(flush), 64'd0);
      chk("hold_rv", 64'(redirect_valid), 64'd1);
      chk("hold_raddr", 64'(redirect_addr), 64'h204);
      chk("hold_bc", 64'(branch_count), 64'd2);
      chk("hold_mc", 64'(mispred_count), 64'd1);
    end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0; idle_in();
    chk("hs_rv", 64'(redirect_valid), 64'd0);
    chk("hs_bc", 64'(branch_count), 64'd2);
    chk("hs_exr", 64'(ex_ready), 64'd1);
    upd_ready = 1'b1; tick(); upd_ready = 1'b0;
    chk("wp_nopush", 64'(upd_valid), 64'd0);

    // Jump mispredict with fetch accepting immediately
    drv(0, 1, 0, 32'h60, 32'h64, 32'h80, 32'h84);
    sb.push_back('{pc: 32'h60, taken: 1'b1, target: 32'h80});
    redirect_ready = 1'b1;
    tick(); idle_in();
    chk("j_rv", 64'(redirect_valid), 64'd1);
    chk("j_flush", 64'(flush), 64'd1);
    chk("j_raddr", 64'(redirect_addr), 64'h80);
    chk("j_utaken", 64'(upd_taken), 64'd1);
    chk("j_mc", 64'(mispred_count), 64'd2);
    tick();
    redirect_ready = 1'b0;
    chk("j_rv_low", 64'(redirect_valid), 64'd0);
    chk("j_flush_low", 64'(flush), 64'd0);
    chk("j_exr", 64'(ex_ready), 64'd1);
    upd_ready = 1'b1; tick(); upd_ready = 1'b0;

    // Valid with neither branch nor jump is ignored
    drv(0, 0, 1, 32'h90, 32'h94, 32'h10, 32'h20);
    tick(); idle_in();
    chk("nf_bc", 64'(branch_count), 64'd3);
    chk("nf_rv", 64'(redirect_valid), 64'd0);
    chk("nf_uvalid", 64'(upd_valid), 64'd0);

    // Fill the FIFO with correct predictions
    for (int i = 0; i < int'(DEPTH); i++) begin
      pc = 32'h1000 + 32'(i * 16); npc = pc + 32'd4; tgt = 32'h2000 + 32'(i * 4);
      tk = 1'(i % 2);
      drv(1, 0, tk, pc, npc, tgt, tk ? tgt : npc);
      sb.push_back('{pc: pc, taken: tk, target: tgt});
      tick();
    end
    idle_in();
    chk("full_exr", 64'(ex_ready), 64'd0);
    chk("full_bc", 64'(branch_count), 64'd7);
    drv(1, 0, 0, 32'h1040, 32'h1044, 32'h3000, 32'h1044);
    tick();
    chk("full_held_bc", 64'(branch_count), 64'd7);
    chk("full_held_exr", 64'(ex_ready), 64'd0);
    upd_ready = 1'b1; tick(); upd_ready = 1'b0;
    chk("full_pop_exr", 64'(ex_ready), 64'd1);
    chk("full_pop_bc", 64'(branch_count), 64'd7);
    chk("full_head", 64'(upd_pc), 64'h1010);
    sb.push_back('{pc: 32'h1040, taken: 1'b0, target: 32'h3000});
    tick(); idle_in();
    chk("full_acc_bc", 64'(branch_count), 64'd8);
    chk("full_acc_exr", 64'(ex_ready), 64'd0);
    upd_ready = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) tick();
    upd_ready = 1'b0;
    chk("full_drained", 64'(upd_valid), 64'd0);

    // Simultaneous push and pop keeps order
    drv(1, 0, 0, 32'h1100, 32'h1104, 32'h1200, 32'h1104);
    sb.push_back('{pc: 32'h1100, taken: 1'b0, target: 32'h1200});
    tick();
    drv(1, 0, 1, 32'h1110, 32'h1114, 32'h1300, 32'h1300);
    sb.push_back('{pc: 32'h1110, taken: 1'b1, target: 32'h1300});
    upd_ready = 1'b1;
    tick(); idle_in(); upd_ready = 1'b0;
    chk("pp_head", 64'(upd_pc), 64'h1110);
    upd_ready = 1'b1; tick(); upd_ready = 1'b0;
    chk("pp_drained", 64'(upd_valid), 64'd0);

    // Reset while a redirect is pending and two records are queued
    drv(1, 0, 0, 32'h700, 32'h704, 32'h800, 32'h704);
    tick();
    drv(1, 0, 1, 32'h710, 32'h714, 32'h900, 32'h714);
    tick(); idle_in();
    chk("pre_rst_rv", 64'(redirect_valid), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mr_rv", 64'(redirect_valid), 64'd0);
    chk("mr_raddr", 64'(redirect_addr), 64'd0);
    chk("mr_flush", 64'(flush), 64'd0);
    chk("mr_uvalid", 64'(upd_valid), 64'd0);
    chk("mr_upc", 64'(upd_pc), 64'd0);
    chk("mr_bc", 64'(branch_count), 64'd0);
    chk("mr_mc", 64'(mispred_count), 64'd0);
    chk("mr_exr", 64'(ex_ready), 64'd1);

    // Counter wrap from a preloaded value
    force dut.branch_count = 32'hFFFF_FFFF;
    tick();
    release dut.branch_count;
    #1;
    chk("wrap_pre", 64'(branch_count), 64'hFFFF_FFFF);
    drv(1, 0, 1, 32'hA00, 32'hA04, 32'hB00, 32'hB00);
    sb.push_back('{pc: 32'hA00, taken: 1'b1, target: 32'hB00});
    tick(); idle_in();
    chk("wrap_bc", 64'(branch_count), 64'd0);
    chk("wrap_mc", 64'(mispred_count), 64'd0);
    upd_ready = 1'b1; tick(); upd_ready = 1'b0;
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
